// File: rtl/dm_load_ctrl.sv
// Write-side front end for a PE data memory: accepts exactly L words per burst
// from a valid/ready stream through a small skid FIFO and replays them as
// sequential memory writes (wea/dina), backing off while a PE write-back owns
// the memory port.
module dm_load_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEN_W      = 9,
    parameter int unsigned MAX_LEN    = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              wb_req,
    output logic              wea,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  wr_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    // registered state
    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   acc_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fcnt;
    logic               hold;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    // next-state values
    state_t             state_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic [LEN_W-1:0]   acc_nxt;
    logic [LEN_W-1:0]   wr_cnt_nxt;
    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [CNT_W-1:0]   fcnt_nxt;
    logic               wea_nxt;
    logic [DATA_W-1:0]  dina_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               s_ready_nxt;
    logic               push;
    logic               pop;
    logic               stall;
    logic [LEN_W-1:0]   len_sat;

    // Transfer qualifiers; a write-back stalls pops for its cycle and the next.
    always_comb begin
        stall   = wb_req | hold;
        push    = s_valid & s_ready;
        pop     = (state == LOAD) && (fcnt != '0) && !stall;
        len_sat = (len > MAX_L) ? MAX_L : len;
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        acc_nxt    = acc_q;
        wr_cnt_nxt = wr_cnt;
        wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        fcnt_nxt   = fcnt + CNT_W'(push) - CNT_W'(pop);
        wea_nxt    = pop;
        dina_nxt   = pop ? mem[rd_ptr] : dina;

        unique case (state)
            IDLE: begin
                if (start) begin
                    len_nxt    = len_sat;
                    acc_nxt    = '0;
                    wr_cnt_nxt = '0;
                    state_nxt  = (len_sat == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (push) acc_nxt = acc_q + LEN_W'(1);
                if (pop)  wr_cnt_nxt = wr_cnt + LEN_W'(1);
                if (wr_cnt == len_q) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt    = (state_nxt == LOAD);
        done_nxt    = (state_nxt == FIN);
        s_ready_nxt = (state_nxt == LOAD) && (fcnt_nxt != DEPTH_C) && (acc_nxt < len_nxt);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            wr_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            hold    <= 1'b0;
            wea     <= 1'b0;
            dina    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            acc_q   <= acc_nxt;
            wr_cnt  <= wr_cnt_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            fcnt    <= fcnt_nxt;
            hold    <= wb_req;
            wea     <= wea_nxt;
            dina    <= dina_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            s_ready <= s_ready_nxt;
        end
    end

    // Skid FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_dm_load_ctrl.sv
// Directed bench for dm_load_ctrl: scoreboard of expected memory writes,
// write-back stall checks and burst bookkeeping checks.
module tb_dm_load_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              wb_req = 1'b0;
    logic              wea;
    logic [DATA_W-1:0] dina;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  wr_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    int          wea_seen  = 0;
    int          done_seen = 0;
    int          cur_l     = 0;
    logic        wb_d1 = 1'b0;
    logic        wb_d2 = 1'b0;

    dm_load_ctrl #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_LEN(256), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wb_req(wb_req), .wea(wea), .dina(dina),
        .busy(busy), .done(done), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    // Output monitor: scoreboard pops, stall window, done/wr_cnt agreement.
    always @(negedge clk) begin
        if (wea === 1'b1) begin
            wea_seen++;
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("dina", dina, exp_q.pop_front());
        end
        if (wb_d1 || wb_d2) chk("wea_in_stall", 32'(wea), 32'd0);
        if (done === 1'b1) begin
            done_seen++;
            chk("wr_cnt_at_done", 32'(wr_cnt), 32'(cur_l));
            chk("busy_at_done", 32'(busy), 32'd0);
        end
        wb_d2 = wb_d1;
        wb_d1 = wb_req;
    end

    task automatic run_burst(input int req_len, input int exp_l, input int n_offer,
                             input logic [31:0] base, input logic [31:0] step,
                             input bit bubbly, input int wb_lo, input int wb_hi,
                             input bit poke, input bit exp_bp, input int abort_at);
        int  idx = 0;
        int  accepted = 0;
        int  k = 0;
        int  tail = 0;
        bit  bp = 1'b0;
        bit  acc_d1 = 1'b0;
        bit  acc_d2 = 1'b0;
        bit  acc_now;
        bit  no_stall = (wb_lo > wb_hi);

        exp_q.delete();
        for (int i = 0; i < exp_l; i++) exp_q.push_back(base + 32'(i) * step);
        wea_seen  = 0;
        done_seen = 0;
        cur_l     = exp_l;

        @(posedge clk); #1;
        start = 1'b1;
        len   = LEN_W'(req_len);
        @(posedge clk); #1;
        start = 1'b0;
        while (k < 700) begin
            s_valid = (idx < n_offer) && (!bubbly || (k % 2 == 0));
            s_data  = base + 32'(idx) * step;
            wb_req  = (k >= wb_lo) && (k <= wb_hi);
            start   = poke && (k == 2 || k == 5);
            len     = poke ? LEN_W'(1) : LEN_W'(req_len);
            @(negedge clk); #1;
            if (k == 0) chk("busy_first", 32'(busy), 32'(exp_l > 0));
            if (no_stall) chk("wea_mirror", 32'(wea), 32'(acc_d2));
            acc_now = s_valid && s_ready;
            if (busy && !s_ready && accepted < exp_l) bp = 1'b1;
            if (acc_now) begin
                idx++;
                accepted++;
            end
            acc_d2 = acc_d1;
            acc_d1 = acc_now;
            if (abort_at >= 0 && wea_seen == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_wea", 32'(wea), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_s_ready", 32'(s_ready), 32'd0);
                chk("abort_wr_cnt", 32'(wr_cnt), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                s_valid = 1'b0;
                wb_req  = 1'b0;
                start   = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b1;
                exp_q.delete();
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done", 32'(done_seen), 32'd0);
                return;
            end
            @(posedge clk); #1;
            k++;
            if (done_seen > 0) begin
                tail++;
                if (tail > 3) break;
            end
        end
        s_valid = 1'b0;
        wb_req  = 1'b0;
        start   = 1'b0;
        chk("budget", 32'(k < 700), 32'd1);
        chk("accepted", 32'(accepted), 32'(exp_l));
        chk("writes", 32'(wea_seen), 32'(exp_l));
        chk("done_pulses", 32'(done_seen), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("wr_cnt_hold", 32'(wr_cnt), 32'(exp_l));
        chk("backpressure", 32'(bp), 32'(exp_bp));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_dina", dina, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-burst, then a normal short burst
        run_burst(8, 8, 8, 32'hC000_0000, 32'd1, 1'b0, 1, 0, 1'b0, 1'b0, 3);
        run_burst(2, 2, 4, 32'hD000_0000, 32'd3, 1'b0, 1, 0, 1'b0, 1'b0, -1);

        // basic burst 0x11..0x44
        run_burst(4, 4, 6, 32'h11, 32'h11, 1'b0, 1, 0, 1'b0, 1'b0, -1);

        // write-back stalls: long one fills the FIFO, single pulse defers one write
        run_burst(8, 8, 10, 32'hA000_0000, 32'd1, 1'b0, 3, 5, 1'b0, 1'b1, -1);
        run_burst(6, 6, 8, 32'hB000_0000, 32'd5, 1'b0, 3, 3, 1'b0, 1'b0, -1);

        // zero and oversize lengths
        run_burst(0, 0, 2, 32'hE000_0000, 32'd1, 1'b0, 1, 0, 1'b0, 1'b0, -1);
        run_burst(300, 256, 260, 32'h0001_0000, 32'd7, 1'b0, 1, 0, 1'b0, 1'b0, -1);

        // bubbly source with ignored start pulses while busy
        run_burst(5, 5, 7, 32'h5A5A_0000, 32'h101, 1'b1, 1, 0, 1'b1, 1'b0, -1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
